// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor.
// The WIDTH-bit operation is cut into STAGES equal slices; slice k is added
// in rank k+1 of the pipeline, with the carry registered between ranks.
// Rank 0 captures the operands (B already conditioned for subtract) so the
// result appears STAGES clock edges after the accepting edge. Not-yet-used
// operand slices ride forward in skew registers, and finished sum slices
// ride forward in deskew registers so the whole sum leaves aligned.
// The pipeline advances as one unit: it holds only when a valid result is
// waiting at the output and the consumer is not ready.
// WIDTH must be an exact multiple of STAGES.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    // Rank r valid bit; rank 0 is operand capture, rank STAGES is the output.
    logic [STAGES:0]  vld_r;
    // Carry entering the slice computed from rank r (rank 0: effective cin).
    logic [STAGES:0]  carry_r;
    // Operand skew registers feeding slice k from rank k.
    logic [WIDTH-1:0] opa_r [0:STAGES-1];
    logic [WIDTH-1:0] opb_r [0:STAGES-1];
    // Partial sums: slices below r are complete in rank r.
    logic [WIDTH-1:0] psum_r [0:STAGES];
    logic             ovf_r;

    logic             adv_s;
    logic [SW-1:0]    slice_sum_s [0:STAGES-1];
    logic [STAGES-1:0] slice_carry_s;
    logic [WIDTH-1:0] psum_nxt_s [0:STAGES-1];
    logic             msb_cin_s;

    // A full result that cannot leave freezes every rank; otherwise bubbles move.
    assign adv_s    = !(vld_r[STAGES] && !out_ready);
    assign in_ready = adv_s;

    assign out_valid = vld_r[STAGES];
    assign sum       = psum_r[STAGES];
    assign cout      = carry_r[STAGES];
    assign ovf       = ovf_r;

    // Slice adders: each rank adds its own slice and patches it into the partial sum.
    always_comb begin
        slice_carry_s = '0;
        msb_cin_s     = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            {slice_carry_s[k], slice_sum_s[k]} =
                {1'b0, opa_r[k][k*SW +: SW]} +
                {1'b0, opb_r[k][k*SW +: SW]} +
                {{SW{1'b0}}, carry_r[k]};
            psum_nxt_s[k] = psum_r[k];
            psum_nxt_s[k][k*SW +: SW] = slice_sum_s[k];
        end
        // The carry into the MSB is recovered from the MSB's own sum bit.
        msb_cin_s = opa_r[STAGES-1][WIDTH-1] ^ opb_r[STAGES-1][WIDTH-1] ^
                    slice_sum_s[STAGES-1][SW-1];
    end

    // Pipeline ranks: capture, slice results, skew/deskew transport, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r   <= '0;
            carry_r <= '0;
            ovf_r   <= 1'b0;
            for (int r = 0; r < STAGES; r++) begin
                opa_r[r] <= '0;
                opb_r[r] <= '0;
            end
            for (int r = 0; r <= STAGES; r++) begin
                psum_r[r] <= '0;
            end
        end else if (adv_s) begin
            vld_r[0]  <= in_valid;
            psum_r[0] <= '0;
            if (in_valid) begin
                opa_r[0]   <= a;
                opb_r[0]   <= sub ? ~b : b;
                carry_r[0] <= sub ? 1'b1 : cin;
            end
            for (int k = 0; k < STAGES; k++) begin
                vld_r[k+1]   <= vld_r[k];
                carry_r[k+1] <= slice_carry_s[k];
                psum_r[k+1]  <= psum_nxt_s[k];
            end
            for (int k = 1; k < STAGES; k++) begin
                opa_r[k] <= opa_r[k-1];
                opb_r[k] <= opb_r[k-1];
            end
            ovf_r <= msb_cin_s ^ slice_carry_s[STAGES-1];
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors, streaming,
// stall, random flow control, reset mid-flight and latency vs STAGES.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;

    logic        in_ready4, out_valid4, cout4, ovf4;
    logic [31:0] sum4;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [31:0] sum1;
    logic        in_ready8, out_valid8, cout8, ovf8;
    logic [31:0] sum8;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q [$];

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid4),
        .out_ready(out_ready), .sum(sum4), .cout(cout4), .ovf(ovf4));

    pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1),
        .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1));

    pipelined_adder #(.WIDTH(32), .STAGES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid8),
        .out_ready(out_ready), .sum(sum8), .cout(cout8), .ovf(ovf8));

    always #5 clk = ~clk;

    // Reference: signed arithmetic for overflow, unsigned compare for carry/borrow.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        longint          sx, sy, r;
        longint unsigned ux, uy;
        logic            co, ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = s ? (sx - sy) : (sx + sy + (ci ? 64'sd1 : 64'sd0));
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        co = s ? (ux >= uy) : ((ux + uy + (ci ? 64'd1 : 64'd0)) >= 64'd4294967296);
        return {ov, co, r[31:0]};
    endfunction

    task automatic drive_random();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid4, cout4, ovf4, sum4} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b c=%0b o=%0b s=%0h, expected all 0",
                     out_valid4, cout4, ovf4, sum4);
        end
        checks++;
        if (in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b expected 1", in_ready4);
        end
        checks++;
        if (out_valid1 !== 1'b0 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_other_valid: got %0b/%0b expected 0/0", out_valid1, out_valid8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'd36865, 32'd9943121, -32'sd3686, -32'sd3686, 32'h7FFFFFFF, 32'hFFFFFFFF};
        logic [31:0] tb [6] = '{32'd33023, -32'sd3302367, 32'd3023, 32'd3023, 32'd1, 32'd0};
        logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] es [6] = '{32'd69888, 32'd6640754, -32'sd663, -32'sd6709, 32'h80000000, 32'd0};
        logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i]; sub = ts[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid4 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat);
            end
            checks++;
            if (sum4 !== es[i] || cout4 !== ec[i] || ovf4 !== eo[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got s=%0h c=%0b o=%0b expected s=%0h c=%0b o=%0b",
                         i, sum4, cout4, ovf4, es[i], ec[i], eo[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid4 !== 1'b0) begin
                errors++;
                $display("FAIL directed_single[%0d]: out_valid got %0b expected 0", i, out_valid4);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_acc = -1, first_out = -1, last_out = -1, got = 0;
        logic [33:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int it = 0; it < 20; it++) begin
            in_valid = (it < 8);
            drive_random();
            @(negedge clk);
            if (in_valid && in_ready4) begin
                exp_q.push_back(model(a, b, cin, sub));
                if (first_acc < 0) first_acc = it;
            end
            if (out_valid4 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got s=%0h expected no result", sum4);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf4, cout4, sum4} !== e) begin
                        errors++;
                        $display("FAIL b2b_result: got %0h expected %0h", {ovf4, cout4, sum4}, e);
                    end
                end
                if (first_out < 0) first_out = it;
                last_out = it;
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (first_out - first_acc - 1 !== 4) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected 4", first_out - first_acc - 1);
        end
        checks++;
        if (got !== 8 || last_out - first_out !== 7) begin
            errors++;
            $display("FAIL b2b_stream: got %0d results over %0d cycles expected 8 over 7",
                     got, last_out - first_out);
        end
    endtask

    task automatic test_stall();
        int sent = 0, got = 0;
        logic held = 1'b0;
        logic [33:0] hold_v, e;
        exp_q.delete();
        for (int it = 0; it < 60 && got < 10; it++) begin
            in_valid  = (sent < 10);
            out_ready = !(it >= 6 && it <= 8);
            drive_random();
            @(negedge clk);
            checks++;
            if (in_ready4 !== !(out_valid4 && !out_ready)) begin
                errors++;
                $display("FAIL stall_in_ready: got %0b expected %0b", in_ready4, !(out_valid4 && !out_ready));
            end
            if (out_valid4 && !out_ready) begin
                if (held) begin
                    checks++;
                    if ({ovf4, cout4, sum4} !== hold_v) begin
                        errors++;
                        $display("FAIL stall_hold: got %0h expected %0h", {ovf4, cout4, sum4}, hold_v);
                    end
                end
                held = 1'b1;
                hold_v = {ovf4, cout4, sum4};
            end
            if (in_valid && in_ready4) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
            end
            if (out_valid4 && out_ready) begin
                held = 1'b0;
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3FFFFFFFF;
                if ({ovf4, cout4, sum4} !== e) begin
                    errors++;
                    $display("FAIL stall_result: got %0h expected %0h", {ovf4, cout4, sum4}, e);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got !== 10 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL stall_count: got %0d results, %0d pending expected 10, 0", got, exp_q.size());
        end
    endtask

    task automatic test_random();
        int got = 0, sent = 0;
        logic [33:0] e;
        exp_q.delete();
        for (int it = 0; it < 90; it++) begin
            in_valid  = (it < 80) && ($urandom_range(0, 9) < 7);
            out_ready = (it >= 80) || ($urandom_range(0, 9) < 7);
            drive_random();
            @(negedge clk);
            if (in_valid && in_ready4) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
            end
            if (out_valid4 && out_ready) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3FFFFFFFF;
                if ({ovf4, cout4, sum4} !== e) begin
                    errors++;
                    $display("FAIL random_result: got %0h expected %0h", {ovf4, cout4, sum4}, e);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got !== sent || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL random_count: got %0d results expected %0d", got, sent);
        end
    endtask

    task automatic test_reset_midflight();
        int lat = 0;
        logic stale = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            drive_random();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: out_valid got %0b expected 1", out_valid4);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid4 !== 1'b0 || sum4 !== 32'd0 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_clear: got v=%0b s=%0h r=%0b expected v=0 s=0 r=1",
                     out_valid4, sum4, in_ready4);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (out_valid4 || out_valid1 || out_valid8) stale = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: got stale result expected none");
        end
    endtask

    task automatic test_latency_params();
        int l1 = -1, l4 = -1, l8 = -1;
        logic [31:0] s1 = 32'd0, s8 = 32'd0;
        out_ready = 1'b1;
        a = 32'd36865; b = 32'd33023; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_valid1 && l1 < 0) begin l1 = c; s1 = sum1; end
            if (out_valid4 && l4 < 0) l4 = c;
            if (out_valid8 && l8 < 0) begin l8 = c; s8 = sum8; end
        end
        checks++;
        if (l1 !== 1 || l4 !== 4 || l8 !== 8) begin
            errors++;
            $display("FAIL latency_stages: got %0d/%0d/%0d expected 1/4/8", l1, l4, l8);
        end
        checks++;
        if (s1 !== 32'd69888 || s8 !== 32'd69888) begin
            errors++;
            $display("FAIL latency_sums: got %0d/%0d expected 69888/69888", s1, s8);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        test_latency_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
